// File: rtl/sobel_window_ctrl_if.sv
// rtl/sobel_window_ctrl_if.sv - pixel stream, window and gradient qualifier bundle of sobel_window_ctrl
interface sobel_window_ctrl_if #(
    parameter int NBIT = 8,
    parameter int COLW = 10,
    parameter int ROWW = 9
);
    logic                        i_start;
    logic [NBIT-1:0]             i_pix;
    logic                        i_pix_valid;
    logic                        o_pix_ready;
    logic [2:0][2:0][NBIT-1:0]   o_window;
    logic                        o_win_valid;
    logic                        o_grad_valid;
    logic [COLW-1:0]             o_grad_x;
    logic [ROWW-1:0]             o_grad_y;
    logic                        o_busy;
    logic                        o_frame_done;

    modport slave (
        input  i_start, i_pix, i_pix_valid,
        output o_pix_ready, o_window, o_win_valid, o_grad_valid,
               o_grad_x, o_grad_y, o_busy, o_frame_done
    );

    modport master (
        output i_start, i_pix, i_pix_valid,
        input  o_pix_ready, o_window, o_win_valid, o_grad_valid,
               o_grad_x, o_grad_y, o_busy, o_frame_done
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - raster frame sequencer and 3x3 window generator for the Sobel stage
module sobel_window_ctrl #(
    parameter int NBIT        = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3,
    parameter int COLW        = $clog2(IMG_WIDTH),
    parameter int ROWW        = $clog2(IMG_HEIGHT)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sobel_window_ctrl_if.slave bus
);
    localparam int K = KERNEL_SIZE;
    localparam int L = KERNEL_SIZE - 1;
    localparam logic [COLW-1:0] X_MAX = COLW'(IMG_WIDTH - 1);
    localparam logic [ROWW-1:0] Y_MAX = ROWW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                      state_q;
    logic [COLW-1:0]             x_q, cx_q, grad_x_q;
    logic [ROWW-1:0]             y_q, cy_q, grad_y_q;
    logic                        pix_ready_q, busy_q, drain_q;
    logic                        win_valid_q, grad_valid_q, last_q, frame_done_q;
    logic [K-1:0][K-1:0][NBIT-1:0] win_q;
    logic [NBIT-1:0]             lb0_q [IMG_WIDTH];
    logic [NBIT-1:0]             lb1_q [IMG_WIDTH];
    logic                        xfer;
    logic [NBIT-1:0]             lb0_rd, lb1_rd;

    assign xfer   = (state_q == RUN) && bus.i_pix_valid;
    assign lb0_rd = lb0_q[x_q];
    assign lb1_rd = lb1_q[x_q];

    // Line buffers carry no reset; the x,y >= 2 validity rule hides stale contents.
    always_ff @(posedge i_clk) begin
        if (xfer) begin
            lb1_q[x_q] <= lb0_rd;
            lb0_q[x_q] <= bus.i_pix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            grad_x_q     <= '0;
            grad_y_q     <= '0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            drain_q      <= 1'b0;
            win_valid_q  <= 1'b0;
            grad_valid_q <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
        end else begin
            win_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            grad_valid_q <= win_valid_q;
            frame_done_q <= last_q;
            if (win_valid_q) begin
                grad_x_q <= cx_q;
                grad_y_q <= cy_q;
            end

            case (state_q)
                IDLE: begin
                    x_q <= '0;
                    y_q <= '0;
                    if (bus.i_start) begin
                        state_q     <= RUN;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (x_q == X_MAX) begin
                            x_q <= '0;
                            if (y_q == Y_MAX) begin
                                state_q     <= DRAIN;
                                pix_ready_q <= 1'b0;
                                drain_q     <= 1'b0;
                                last_q      <= 1'b1;
                            end else begin
                                y_q <= y_q + ROWW'(1);
                            end
                        end else begin
                            x_q <= x_q + COLW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles: lets the final window and gradient leave before IDLE.
                    if (drain_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase

            if (xfer) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < L; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                end
                win_q[L][L] <= bus.i_pix;
                win_q[1][L] <= lb0_rd;
                win_q[0][L] <= lb1_rd;
                win_valid_q <= (x_q >= COLW'(2)) && (y_q >= ROWW'(2));
                cx_q        <= x_q - COLW'(1);
                cy_q        <= y_q - ROWW'(1);
            end
        end
    end

    assign bus.o_pix_ready  = pix_ready_q;
    assign bus.o_window     = win_q;
    assign bus.o_win_valid  = win_valid_q;
    assign bus.o_grad_valid = grad_valid_q;
    assign bus.o_grad_x     = grad_x_q;
    assign bus.o_grad_y     = grad_y_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - self-checking bench for sobel_window_ctrl on a 5x4 frame
module tb_sobel_window_ctrl;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NB   = 8;
    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    typedef logic [2:0][2:0][NB-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.NBIT(NB), .COLW(CW), .ROWW(RW)) bus ();

    sobel_window_ctrl #(
        .NBIT(NB), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(3), .COLW(CW), .ROWW(RW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [NB-1:0] frame [NPIX];

    win_t cap_win[$];
    int   cap_gx[$], cap_gy[$], win_cyc[$], xfer_cyc[$], done_cyc[$], done_at[$];
    int   bad_win = 0;
    bit   xfer_prev = 1'b0;

    always @(posedge clk) begin
        xfer_prev = bus.i_pix_valid && bus.o_pix_ready && rst_n;
        if (xfer_prev) xfer_cyc.push_back(cyc);
        cyc++;
    end

    always @(negedge clk) begin
        if (bus.o_win_valid) begin
            cap_win.push_back(bus.o_window);
            win_cyc.push_back(cyc);
            if (!xfer_prev) bad_win++;
        end
        if (bus.o_grad_valid) begin
            cap_gx.push_back(int'(bus.o_grad_x));
            cap_gy.push_back(int'(bus.o_grad_y));
        end
        if (bus.o_frame_done) begin
            done_cyc.push_back(cyc);
            done_at.push_back(cap_gx.size());
        end
    end

    function automatic win_t exp_win(input int k);
        win_t w;
        int cx = 2 + k % (W - 2);
        int cy = 2 + k / (W - 2);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = frame[(cy - 2 + r) * W + (cx - 2 + c)];
        return w;
    endfunction

    task automatic clear_cap();
        cap_win.delete(); cap_gx.delete(); cap_gy.delete(); win_cyc.delete();
        xfer_cyc.delete(); done_cyc.delete(); done_at.delete();
        bad_win = 0;
    endtask

    task automatic fill_frame(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0:       frame[i] = NB'(i);
                1:       frame[i] = ((i % W) < 2) ? 8'd0 : 8'd255;
                default: frame[i] = NB'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic run_frames(input int nframes, input bit gaps, input bit hold_start,
                              input bit poke_start, input bit tail_valid, output bit ok);
        int guard = 0;
        int guard2 = 0;
        ok = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b1;
        if (!hold_start) begin
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        while (xfer_cyc.size() < nframes * NPIX && guard < 2000) begin
            bus.i_pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_pix = frame[xfer_cyc.size() % NPIX];
            if (poke_start) bus.i_start = (xfer_cyc.size() == 9);
            @(negedge clk);
            guard++;
        end
        bus.i_start = 1'b0;
        bus.i_pix_valid = tail_valid;
        while (bus.o_busy && guard2 < 50) begin
            @(negedge clk);
            guard2++;
        end
        repeat (3) @(negedge clk);
        bus.i_pix_valid = 1'b0;
        if (guard >= 2000 || guard2 >= 50) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0; bus.i_pix = '0; bus.i_pix_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_pix_ready, bus.o_win_valid, bus.o_grad_valid, bus.o_frame_done, bus.o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b need 00000", {bus.o_pix_ready, bus.o_win_valid,
                     bus.o_grad_valid, bus.o_frame_done, bus.o_busy});
        end
        checks++;
        if (bus.o_grad_x !== '0 || bus.o_grad_y !== '0 || bus.o_window !== '0) begin
            errors++;
            $display("FAIL reset_data got x=%0d y=%0d win=%h need zeros", bus.o_grad_x, bus.o_grad_y, bus.o_window);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        bit ok;
        clear_cap(); fill_frame(0);
        run_frames(1, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_timeout got timeout need completion"); end
        checks++;
        if (cap_win.size() != NWIN || cap_gx.size() != NWIN) begin
            errors++; $display("FAIL cont_count got %0d/%0d need %0d", cap_win.size(), cap_gx.size(), NWIN);
        end else begin
            for (int k = 0; k < NWIN; k++) begin
                checks++;
                if (cap_win[k] !== exp_win(k) || cap_gx[k] != k % (W - 2) + 1 || cap_gy[k] != k / (W - 2) + 1) begin
                    errors++;
                    $display("FAIL cont_win%0d got %h (%0d,%0d) need %h (%0d,%0d)", k, cap_win[k], cap_gx[k],
                             cap_gy[k], exp_win(k), k % (W - 2) + 1, k / (W - 2) + 1);
                end
            end
            checks++;
            if (win_cyc[0] != xfer_cyc[12] + 1) begin
                errors++; $display("FAIL cont_first_win got cycle %0d need %0d", win_cyc[0], xfer_cyc[12] + 1);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++; $display("FAIL cont_done_count got %0d need 1", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != xfer_cyc[NPIX-1] + 2 || done_at[0] != NWIN) begin
                errors++; $display("FAIL cont_done_time got cyc %0d grad#%0d need cyc %0d grad#%0d",
                                   done_cyc[0], done_at[0], xfer_cyc[NPIX-1] + 2, NWIN);
            end
        end
    endtask

    task automatic test_vertical_edge();
        bit ok;
        int gx, gy, egx;
        clear_cap(); fill_frame(1);
        run_frames(1, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || cap_win.size() != NWIN) begin
            errors++; $display("FAIL edge_count got %0d ok=%0d need %0d", cap_win.size(), ok, NWIN);
        end else begin
            for (int k = 0; k < NWIN; k++) begin
                gx = (int'(cap_win[k][0][0]) + 2 * int'(cap_win[k][1][0]) + int'(cap_win[k][2][0]))
                   - (int'(cap_win[k][0][2]) + 2 * int'(cap_win[k][1][2]) + int'(cap_win[k][2][2]));
                gy = (int'(cap_win[k][0][0]) + 2 * int'(cap_win[k][0][1]) + int'(cap_win[k][0][2]))
                   - (int'(cap_win[k][2][0]) + 2 * int'(cap_win[k][2][1]) + int'(cap_win[k][2][2]));
                egx = (cap_gx[k] == 3) ? 0 : -1020;
                checks++;
                if (gx != egx || gy != 0) begin
                    errors++; $display("FAIL edge_grad%0d got gx=%0d gy=%0d need gx=%0d gy=0", k, gx, gy, egx);
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit ok;
        clear_cap(); fill_frame(2);
        run_frames(1, 1'b1, 1'b0, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || cap_win.size() != NWIN || cap_gx.size() != NWIN) begin
            errors++; $display("FAIL gaps_count got %0d ok=%0d need %0d", cap_win.size(), ok, NWIN);
        end else begin
            for (int k = 0; k < NWIN; k++) begin
                checks++;
                if (cap_win[k] !== exp_win(k) || cap_gx[k] != k % (W - 2) + 1 || cap_gy[k] != k / (W - 2) + 1) begin
                    errors++; $display("FAIL gaps_win%0d got %h (%0d,%0d) need %h", k, cap_win[k], cap_gx[k],
                                       cap_gy[k], exp_win(k));
                end
            end
        end
        checks++;
        if (bad_win != 0) begin errors++; $display("FAIL gaps_stray_valid got %0d need 0", bad_win); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int guard = 0;
        clear_cap(); fill_frame(2);
        @(negedge clk); bus.i_start = 1'b1;
        @(negedge clk); bus.i_start = 1'b0;
        while (xfer_cyc.size() < 7 && guard < 100) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix = frame[xfer_cyc.size()];
            @(negedge clk);
            guard++;
        end
        bus.i_pix_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_pix_ready, bus.o_win_valid, bus.o_grad_valid, bus.o_frame_done, bus.o_busy} !== 5'b0
            || bus.o_window !== '0 || bus.o_grad_x !== '0 || bus.o_grad_y !== '0) begin
            errors++; $display("FAIL midrst_outputs got rdy=%b busy=%b win=%h need zeros",
                               bus.o_pix_ready, bus.o_busy, bus.o_window);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (done_cyc.size() != 0 || xfer_cyc.size() != 7) begin
            errors++; $display("FAIL midrst_abandon got done=%0d xfers=%0d need 0/7", done_cyc.size(), xfer_cyc.size());
        end
        clear_cap();
        run_frames(1, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || cap_win.size() != NWIN || done_cyc.size() != 1) begin
            errors++; $display("FAIL midrst_refill got win=%0d done=%0d need %0d/1", cap_win.size(), done_cyc.size(), NWIN);
        end else begin
            for (int k = 0; k < NWIN; k++) begin
                checks++;
                if (cap_win[k] !== exp_win(k) || cap_gx[k] != k % (W - 2) + 1 || cap_gy[k] != k / (W - 2) + 1) begin
                    errors++; $display("FAIL midrst_win%0d got %h need %h", k, cap_win[k], exp_win(k));
                end
            end
        end
    endtask

    task automatic test_ignored();
        bit ok;
        clear_cap(); fill_frame(0);
        bus.i_pix_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (xfer_cyc.size() != 0) begin errors++; $display("FAIL idle_consume got %0d need 0", xfer_cyc.size()); end
        run_frames(1, 1'b0, 1'b0, 1'b1, 1'b1, ok);
        checks++;
        if (!ok || xfer_cyc.size() != NPIX) begin
            errors++; $display("FAIL ignored_pixcount got %0d need %0d", xfer_cyc.size(), NPIX);
        end
        checks++;
        if (cap_gx.size() != NWIN || done_cyc.size() != 1) begin
            errors++; $display("FAIL ignored_count got %0d/%0d need %0d/1", cap_gx.size(), done_cyc.size(), NWIN);
        end else begin
            for (int k = 0; k < NWIN; k++) begin
                checks++;
                if (cap_win[k] !== exp_win(k) || cap_gx[k] != k % (W - 2) + 1 || cap_gy[k] != k / (W - 2) + 1) begin
                    errors++; $display("FAIL ignored_win%0d got %h (%0d,%0d) need %h", k, cap_win[k], cap_gx[k],
                                       cap_gy[k], exp_win(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_cap(); fill_frame(2);
        run_frames(2, 1'b0, 1'b1, 1'b0, 1'b0, ok);
        checks++;
        if (!ok || cap_win.size() != 2 * NWIN || done_cyc.size() != 2 || xfer_cyc.size() != 2 * NPIX) begin
            errors++; $display("FAIL b2b_count got win=%0d done=%0d xfer=%0d need %0d/2/%0d",
                               cap_win.size(), done_cyc.size(), xfer_cyc.size(), 2 * NWIN, 2 * NPIX);
        end else begin
            checks++;
            if (xfer_cyc[NPIX] != xfer_cyc[NPIX-1] + 4) begin
                errors++; $display("FAIL b2b_restart got cycle %0d need %0d", xfer_cyc[NPIX], xfer_cyc[NPIX-1] + 4);
            end
            for (int k = 0; k < 2 * NWIN; k++) begin
                checks++;
                if (cap_win[k] !== exp_win(k % NWIN) || cap_gx[k] != (k % NWIN) % (W - 2) + 1
                    || cap_gy[k] != (k % NWIN) / (W - 2) + 1) begin
                    errors++; $display("FAIL b2b_win%0d got %h need %h", k, cap_win[k], exp_win(k % NWIN));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_vertical_edge();
        test_gaps();
        test_mid_reset();
        test_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
